// File: rtl/mem_arbiter.sv
// Two-port (A = CPU, B = DMA/debug) arbiter onto a single-ported data memory; one access per 3 cycles.
// Optional starvation guard for port B is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        A_Req,
  input  logic        A_We,
  input  logic [31:0] A_Addr,
  input  logic [31:0] A_WData,
  output logic        A_Ack,
  output logic        A_Err,
  input  logic        B_Req,
  input  logic        B_We,
  input  logic [31:0] B_Addr,
  input  logic [31:0] B_WData,
  output logic        B_Ack,
  output logic        B_Err,
  output logic [31:0] RData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;
  logic        anyReq;
  logic        pickB;
  logic        forceB;
  logic        grantB;
  logic        latWe;
  logic [31:0] latAddr;
  logic [31:0] latWData;
  logic        errReg;
  logic [31:0] rDataReg;
  logic        aligned;

  assign anyReq  = A_Req | B_Req;
  assign pickB   = B_Req & (~A_Req | forceB);
  assign aligned = (latAddr[1:0] == 2'b00);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] MaxWait = 3'(MAX_WAIT);
  logic [2:0] waitCnt;

  assign forceB = (waitCnt == MaxWait);

  // Counts A wins while B is waiting; saturates so B is forced on the next contended slot.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      waitCnt <= 3'd0;
    end else if (state == IDLE) begin
      if (!B_Req || pickB) begin
        waitCnt <= 3'd0;
      end else if (waitCnt != MaxWait) begin
        waitCnt <= waitCnt + 3'd1;
      end
    end
  end
`else
  assign forceB = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: nextState gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS:  nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Winner's command is frozen here; later Req/Addr/WData changes cannot disturb the access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grantB   <= 1'b0;
      latWe    <= 1'b0;
      latAddr  <= 32'd0;
      latWData <= 32'd0;
    end else if (state == IDLE && anyReq) begin
      grantB   <= pickB;
      latWe    <= pickB ? B_We    : A_We;
      latAddr  <= pickB ? B_Addr  : A_Addr;
      latWData <= pickB ? B_WData : A_WData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      errReg   <= 1'b0;
      rDataReg <= 32'd0;
    end else if (state == ACCESS) begin
      errReg   <= ~aligned;
      rDataReg <= (aligned && !latWe) ? MemRData : 32'd0;
    end
  end

  assign MemAddr  = latAddr;
  assign MemWData = latWData;
  assign MemWrite = (state == ACCESS) &  aligned &  latWe;
  assign MemRead  = (state == ACCESS) &  aligned & ~latWe;
  assign RData    = rDataReg;

  assign A_Ack = (state == RESP) & ~grantB;
  assign B_Ack = (state == RESP) &  grantB;
  assign A_Err = A_Ack & errReg;
  assign B_Err = B_Ack & errReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued when a request is driven
// and popped when an Ack appears. Expected contention order follows ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  localparam int MW = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        A_Req, A_We, B_Req, B_We;
  logic [31:0] A_Addr, A_WData, B_Addr, B_WData;
  logic        A_Ack, A_Err, B_Ack, B_Err;
  logic [31:0] RData, MemAddr, MemWData, MemRData;
  logic        MemWrite, MemRead;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  typedef struct {
    logic        isB;
    logic        err;
    logic        chkData;
    logic [31:0] rdata;
  } expT;

  expT sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  mem_arbiter #(.MAX_WAIT(MW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .A_Req(A_Req), .A_We(A_We), .A_Addr(A_Addr), .A_WData(A_WData), .A_Ack(A_Ack), .A_Err(A_Err),
    .B_Req(B_Req), .B_We(B_We), .B_Addr(B_Addr), .B_WData(B_WData), .B_Ack(B_Ack), .B_Err(B_Err),
    .RData(RData), .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  assign MemRData = mem[MemAddr[11:2]];
  always @(posedge Clk) if (MemWrite) mem[MemAddr[11:2]] <= MemWData;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idleInputs();
    A_Req = 1'b0; A_We = 1'b0; A_Addr = 32'd0; A_WData = 32'd0;
    B_Req = 1'b0; B_We = 1'b0; B_Addr = 32'd0; B_WData = 32'd0;
  endtask

  task automatic popAndCompare(input string tag);
    expT e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected_ack"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_port"}, 32'(B_Ack), 32'(e.isB));
    check({tag, "_both_ack"}, 32'(A_Ack & B_Ack), 32'd0);
    check({tag, "_err"}, 32'(e.isB ? B_Err : A_Err), 32'(e.err));
    if (e.chkData) check({tag, "_rdata"}, RData, e.rdata);
  endtask

  // Single access on one port, started in an IDLE cycle; checks ACCESS strobes and latency.
  task automatic access(input string tag, input logic isB, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    expT        e;
    logic [9:0] idx;
    logic       misal;
    int         cyc;
    idx       = addr[11:2];
    misal     = (addr[1:0] != 2'b00);
    e.isB     = isB;
    e.err     = misal;
    e.chkData = !we || misal;
    e.rdata   = (!we && !misal) ? shadow[idx] : 32'd0;
    if (we && !misal) shadow[idx] = wdata;
    sb.push_back(e);

    @(negedge Clk);
    idleInputs();
    if (isB) begin
      B_Req = 1'b1; B_We = we; B_Addr = addr; B_WData = wdata;
    end else begin
      A_Req = 1'b1; A_We = we; A_Addr = addr; A_WData = wdata;
    end
    @(negedge Clk);
    check({tag, "_memwrite"}, 32'(MemWrite), 32'(we && !misal));
    check({tag, "_memread"},  32'(MemRead),  32'(!we && !misal));
    if (!misal) check({tag, "_memaddr"}, MemAddr, addr);
    cyc = 1;
    while (!(A_Ack | B_Ack) && cyc < 8) begin
      @(negedge Clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    if (A_Ack | B_Ack) popAndCompare(tag);
    else void'(sb.pop_front());
    idleInputs();
  endtask

  task automatic contention();
    expT e;
    int  cyc;
    int  nB;
    int  expB;
    nB   = 0;
    expB = 0;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      e.isB = ((k % (MW + 1)) == MW);
`else
      e.isB = 1'b0;
`endif
      if (e.isB) expB++;
      e.err     = 1'b0;
      e.chkData = 1'b1;
      e.rdata   = e.isB ? shadow[10'h021] : shadow[10'h010];
      sb.push_back(e);
    end
    @(negedge Clk);
    A_Req = 1'b1; A_We = 1'b0; A_Addr = 32'h40;
    B_Req = 1'b1; B_We = 1'b0; B_Addr = 32'h84;
    for (int k = 0; k < 10; k++) begin
      cyc = 0;
      do begin
        @(negedge Clk);
        cyc++;
      end while (!(A_Ack | B_Ack) && cyc < 8);
      check("cont_gap", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
      if (B_Ack) nB++;
      if (A_Ack | B_Ack) popAndCompare("cont");
      else void'(sb.pop_front());
    end
    idleInputs();
    check("cont_b_acks", 32'(nB), 32'(expB));
  endtask

  initial begin
    int   cyc;
    logic sawAck;
    logic isB, we;
    logic [31:0] addr;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = (32'(i) * 32'h0001_0001) ^ 32'h5A5A_0000;
      shadow[i] = mem[i];
    end
    mem[10'h010]    = 32'hDEAD_BEEF;
    shadow[10'h010] = 32'hDEAD_BEEF;
    idleInputs();
    Reset_n = 1'b0;
    #12;
    check("rst_flags", 32'({A_Ack, B_Ack, A_Err, B_Err, MemWrite, MemRead}), 32'd0);
    check("rst_rdata", RData, 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    access("read_a",      1'b0, 1'b0, 32'h40, 32'd0);
    access("write_b",     1'b1, 1'b1, 32'h80, 32'h1234_5678);
    access("readback_b",  1'b1, 1'b0, 32'h80, 32'd0);
    access("misal_a",     1'b0, 1'b1, 32'h42, 32'hFFFF_FFFF);
    access("misal_chk",   1'b0, 1'b0, 32'h40, 32'd0);
    access("misal_b_rd",  1'b1, 1'b0, 32'h83, 32'd0);
    for (int k = 0; k < 8; k++) begin
      isB  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
      access("rand", isB, we, addr, $urandom);
    end

    contention();

    // Reset during the ACCESS cycle of a B write must discard it.
    @(negedge Clk);
    B_Req = 1'b1; B_We = 1'b1; B_Addr = 32'h100; B_WData = 32'hCAFE_F00D;
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_flags", 32'({A_Ack, B_Ack, A_Err, B_Err, MemWrite, MemRead}), 32'd0);
    check("mid_rst_rdata", RData, 32'd0);
    check("mid_rst_memaddr", MemAddr, 32'd0);
    check("mid_rst_memwdata", MemWData, 32'd0);
    idleInputs();
    @(negedge Clk);
    Reset_n = 1'b1;
    sawAck = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (A_Ack | B_Ack) sawAck = 1'b1;
    end
    check("mid_rst_no_ack", 32'(sawAck), 32'd0);
    check("mid_rst_mem_kept", mem[10'h040], shadow[10'h040]);
    access("post_rst_read", 1'b0, 1'b0, 32'h100, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    cyc = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: consecutive A grants B may lose while requesting before forced B grant.
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port A_Req  input  1  port A (CPU) access request, level.
REQ-005 SHALL have port A_We  input  1  port A: 1=write, 0=read.
REQ-006 SHALL have port A_Addr  input  32  port A byte address.
REQ-007 SHALL have port A_WData  input  32  port A write data.
REQ-008 SHALL have port A_Ack  output  1  port A completion pulse.
REQ-009 SHALL have port A_Err  output  1  port A misaligned-address flag, valid with A_Ack.
REQ-010 SHALL have ports B_Req, B_We, B_Addr, B_WData, B_Ack, B_Err, identical to the A ports, for port B (DMA/debug).
REQ-011 SHALL have port RData  output  32  read data, valid in the A_Ack or B_Ack cycle.
REQ-012 SHALL have port MemAddr  output  32  byte address to data memory.
REQ-013 SHALL have port MemWData  output  32  write data to data memory.
REQ-014 SHALL have port MemWrite  output  1  memory write strobe, sampled on rising Clk.
REQ-015 SHALL have port MemRead  output  1  memory read enable.
REQ-016 SHALL have port MemRData  input  32  combinational read data from memory.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles.
REQ-018 IDLE: if any Req high, pick winner and latch winner's We/Addr/WData into internal regs on the edge; go ACCESS. Otherwise stay.
REQ-019 Arbitration: A only -> A; B only -> B; both -> A unless the starvation guard forces B (REQ-030).
REQ-020 ACCESS, aligned (Addr[1:0]==0): MemAddr/MemWData come from latched regs. MemWrite=We. MemRead=~We. Capture MemRData into RData at the edge when We=0.
REQ-021 ACCESS, misaligned: MemWrite=MemRead=0; set Err for the winner; RData=0.
REQ-022 Outside ACCESS: MemWrite=MemRead=0. MemAddr/MemWData hold their last latched value.
REQ-023 RESP: winner's Ack=1 for exactly one cycle, Err per REQ-021. The loser's Ack/Err=0. Then go IDLE.
REQ-024 Requester SHALL hold Req until Ack. Req still high in the IDLE cycle after RESP is a new request.
REQ-025 Req changes during ACCESS/RESP SHALL NOT affect the in-flight access. Addr/WData changes after latch are ignored.
REQ-026 Read latency: Req high in IDLE cycle N -> Ack and RData valid in cycle N+2.
REQ-027 Write latency: memory updated at end of cycle N+1; Ack in N+2.

Reset
REQ-028 Reset_n low SHALL asynchronously force: FSM=IDLE, A_Ack=B_Ack=A_Err=B_Err=0, MemWrite=MemRead=0, RData=0, MemAddr=MemWData=0, wait counter=0.
REQ-029 Reset mid-ACCESS SHALL abort the access: no Ack issued. After Reset_n rises, arbitration restarts in IDLE.

Configuration
REQ-030 With ARB_STARVE_GUARD_EN defined:
- 3-bit WaitCnt increments on each A grant while B_Req=1; saturates at MAX_WAIT.
- Clears on a B grant or when B_Req=0 in IDLE.
- When WaitCnt==MAX_WAIT and both request, B wins.
REQ-031 Without ARB_STARVE_GUARD_EN: strict A priority, no WaitCnt logic; B may starve indefinitely.

Verification
REQ-032 Single read: memory word 0x10 holds 0xDEADBEEF; A_Req, A_We=0, A_Addr=0x40 in cycle 0 -> MemRead=1 in cycle 1; A_Ack=1, RData=0xDEADBEEF in cycle 2.
REQ-033 Write then read: B writes 0x12345678 to 0x80, then reads 0x80 -> RData=0x12345678, B_Err=0.
REQ-034 Misaligned access: A_Addr=0x42, A_We=1 -> MemWrite stays 0; A_Ack=1 with A_Err=1; memory unchanged.
REQ-035 Contention, guard on, MAX_WAIT=4: A_Req and B_Req held continuously -> grant order A,A,A,A,B,A,A,A,A,B.
REQ-036 Contention, guard off: same stimulus for 10 accesses -> all A, B_Ack never asserted.
REQ-037 Reset mid-ACCESS: Reset_n low during a B write -> B_Ack never pulses; all outputs 0; the next request completes normally in 3 cycles.
